// File: rtl/jk_pkg.sv
// jk_pkg
// Shared definitions for the JK register bank:
//   jk_mode_t        - operating mode encoding of the bank's mode input
//   JK_PKG_MAX_WIDTH - largest bank width the top level accepts
package jk_pkg;

  typedef enum logic [1:0] {
    JK_MODE_JK   = 2'b00,
    JK_MODE_UP   = 2'b01,
    JK_MODE_DN   = 2'b10,
    JK_MODE_HOLD = 2'b11
  } jk_mode_t;

  localparam int JK_PKG_MAX_WIDTH = 64;

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// jk_cell
// One-bit JK flip-flop with asynchronous active-low reset, parallel load
// and clock enable. Load has priority over enable.
// Ports:
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous reset, active low (q <- RST_VAL)
//   i_load    synchronous load of i_d
//   i_d       load data
//   i_en      clock enable for JK operation
//   i_j/i_k   J and K inputs (00 hold, 01 clear, 10 set, 11 toggle)
//   o_q       registered state
//   o_q_next  value o_q takes on the next edge (used for change detect)
module jk_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_load,
  input  logic i_d,
  input  logic i_en,
  input  logic i_j,
  input  logic i_k,
  output logic o_q,
  output logic o_q_next
);

  logic r_q;

  always_comb begin
    o_q_next = r_q;
    if (i_load) begin
      o_q_next = i_d;
    end else if (i_en) begin
      case ({i_j, i_k})
        2'b01:   o_q_next = 1'b0;
        2'b10:   o_q_next = 1'b1;
        2'b11:   o_q_next = ~r_q;
        default: o_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= o_q_next;
    end
  end

  assign o_q = r_q;

endmodule : jk_cell

// File: rtl/jk_reg_bank.sv
// jk_reg_bank
// Bank of WIDTH JK flip-flops with per-bit J/K, parallel load, clock enable
// and an optional up/down counter mode built from the same JK cells.
// Configuration macro: JK_COUNT_MODE_EN
//   defined   - modes 01 (up) / 10 (down) count, tc pulses on wrap
//   undefined - counter chain removed, modes 01/10 hold, tc tied to 0
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active low (q <- RST_VAL, tc/chg <- 0)
//   en    clock enable for JK and count operation
//   load  synchronous parallel load (highest priority after reset)
//   d     parallel load data
//   mode  00 JK, 01 count up, 10 count down, 11 hold
//   j/k   per-bit J/K, used only in mode 00
//   q     register state
//   tc    registered terminal-count pulse (count wrap)
//   chg   registered flag: q changed on the last edge
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             chg
);

  if (WIDTH < 1 || WIDTH > JK_PKG_MAX_WIDTH) begin : g_width_check
    $error("jk_reg_bank: WIDTH out of range");
  end

  jk_mode_t         w_mode;
  logic [WIDTH-1:0] w_j_sel;
  logic [WIDTH-1:0] w_k_sel;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_q_next;
  logic             r_chg;

  assign w_mode = jk_mode_t'(mode);

`ifdef JK_COUNT_MODE_EN
  // w_carry[i] = AND of q[i-1:0]; w_carry[WIDTH] means q is all ones.
  // w_borrow[i] = AND of ~q[i-1:0]; w_borrow[WIDTH] means q is zero.
  logic [WIDTH:0] w_carry;
  logic [WIDTH:0] w_borrow;
  logic           r_tc;

  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    assign w_carry[gi+1]  = w_carry[gi] & w_q[gi];
    assign w_borrow[gi+1] = w_borrow[gi] & ~w_q[gi];
  end

  // Wrap happens exactly when the count chain ripples through every bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tc <= 1'b0;
    end else begin
      r_tc <= !load && en &&
              ((w_mode == JK_MODE_UP && w_carry[WIDTH]) ||
               (w_mode == JK_MODE_DN && w_borrow[WIDTH]));
    end
  end

  assign tc = r_tc;
`else
  assign tc = 1'b0;
`endif

  // Per-bit J/K select: counting drives J=K so each cell toggles or holds.
  always_comb begin
    w_j_sel = '0;
    w_k_sel = '0;
    case (w_mode)
      JK_MODE_JK: begin
        w_j_sel = j;
        w_k_sel = k;
      end
`ifdef JK_COUNT_MODE_EN
      JK_MODE_UP: begin
        w_j_sel = w_carry[WIDTH-1:0];
        w_k_sel = w_carry[WIDTH-1:0];
      end
      JK_MODE_DN: begin
        w_j_sel = w_borrow[WIDTH-1:0];
        w_k_sel = w_borrow[WIDTH-1:0];
      end
`endif
      default: begin
        w_j_sel = '0;
        w_k_sel = '0;
      end
    endcase
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell #(
      .RST_VAL (RST_VAL[gi])
    ) u_cell (
      .i_clk    (clk),
      .i_rst_n  (rst),
      .i_load   (load),
      .i_d      (d[gi]),
      .i_en     (en),
      .i_j      (w_j_sel[gi]),
      .i_k      (w_k_sel[gi]),
      .o_q      (w_q[gi]),
      .o_q_next (w_q_next[gi])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_chg <= 1'b0;
    end else begin
      r_chg <= |(w_q_next ^ w_q);
    end
  end

  assign q   = w_q;
  assign chg = r_chg;

endmodule : jk_reg_bank

// File: tb/tb_jk_reg_bank.sv
// tb_jk_reg_bank
// Directed-vector bench for jk_reg_bank with WIDTH=4, RST_VAL=0.
// Count-mode expectations follow whether JK_COUNT_MODE_EN is defined.
module tb_jk_reg_bank;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] d;
  logic [1:0]   mode;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q;
  logic         tc;
  logic         chg;

  int n_pass;
  int n_total;

  jk_reg_bank #(
    .WIDTH   (W),
    .RST_VAL (4'b0000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .load (load),
    .d    (d),
    .mode (mode),
    .j    (j),
    .k    (k),
    .q    (q),
    .tc   (tc),
    .chg  (chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_total++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic expect_state(input string tag, input logic [W-1:0] eq,
                              input logic etc, input logic echg);
    check({tag, ".q"},   {4'b0, q},   {4'b0, eq});
    check({tag, ".tc"},  {7'b0, tc},  {7'b0, etc});
    check({tag, ".chg"}, {7'b0, chg}, {7'b0, echg});
    $display("%s: q=%b tc=%b chg=%b", tag, q, tc, chg);
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1;
    d    = v;
    step();
    load = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst  = 1'b0;
    en   = 1'b0;
    load = 1'b0;
    d    = '0;
    mode = 2'b00;
    j    = '0;
    k    = '0;

    #12;
    expect_state("reset", 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;

    // Async reset between edges
    do_load(4'b1011);
    expect_state("load_1011", 4'b1011, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    expect_state("async_rst", 4'b0000, 1'b0, 1'b0);
    #1;
    rst = 1'b1;

    // JK mode
    en = 1'b1; mode = 2'b00;
    j = 4'b1010; k = 4'b0000; step();
    expect_state("jk_set", 4'b1010, 1'b0, 1'b1);
    j = 4'b0000; k = 4'b0010; step();
    expect_state("jk_clr", 4'b1000, 1'b0, 1'b1);
    j = 4'b1111; k = 4'b1111; step();
    expect_state("jk_tog", 4'b0111, 1'b0, 1'b1);
    j = 4'b0000; k = 4'b0000; step();
    expect_state("jk_hold", 4'b0111, 1'b0, 1'b0);

    // Load priority over en=0 and JK
    en = 1'b0; j = 4'b1111; k = 4'b1111;
    do_load(4'b1001);
    expect_state("load_prio", 4'b1001, 1'b0, 1'b1);
    step();
    expect_state("en0_hold", 4'b1001, 1'b0, 1'b0);

    // Equal-value load gives no change
    do_load(4'b1001);
    expect_state("load_same", 4'b1001, 1'b0, 1'b0);

    // Mode 11 holds even with en=1 and active J/K
    en = 1'b1; mode = 2'b11; step();
    expect_state("mode_hold", 4'b1001, 1'b0, 1'b0);

    // Count up through the wrap
    j = '0; k = '0;
    do_load(4'b1110);
    expect_state("up_load", 4'b1110, 1'b0, 1'b1);
    mode = 2'b01;
`ifdef JK_COUNT_MODE_EN
    step(); expect_state("up1", 4'b1111, 1'b0, 1'b1);
    step(); expect_state("up2", 4'b0000, 1'b1, 1'b1);
    step(); expect_state("up3", 4'b0001, 1'b0, 1'b1);
`else
    step(); expect_state("up1", 4'b1110, 1'b0, 1'b0);
    step(); expect_state("up2", 4'b1110, 1'b0, 1'b0);
    step(); expect_state("up3", 4'b1110, 1'b0, 1'b0);
`endif

    // Count down through the wrap, then reset mid-run
    do_load(4'b0001);
    mode = 2'b10;
`ifdef JK_COUNT_MODE_EN
    step(); expect_state("dn1", 4'b0000, 1'b0, 1'b1);
    step(); expect_state("dn2", 4'b1111, 1'b1, 1'b1);
    step(); expect_state("dn3", 4'b1110, 1'b0, 1'b1);
`else
    step(); expect_state("dn1", 4'b0001, 1'b0, 1'b0);
    step(); expect_state("dn2", 4'b0001, 1'b0, 1'b0);
    step(); expect_state("dn3", 4'b0001, 1'b0, 1'b0);
`endif
    #2;
    rst = 1'b0;
    #1;
    expect_state("dn_rst", 4'b0000, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    step();
`ifdef JK_COUNT_MODE_EN
    expect_state("dn_after_rst", 4'b1111, 1'b1, 1'b1);
`else
    expect_state("dn_after_rst", 4'b0000, 1'b0, 1'b0);
`endif

    // Count up from 0101 for three edges
    do_load(4'b0101);
    mode = 2'b01;
`ifdef JK_COUNT_MODE_EN
    step(); expect_state("cu1", 4'b0110, 1'b0, 1'b1);
    step(); expect_state("cu2", 4'b0111, 1'b0, 1'b1);
    step(); expect_state("cu3", 4'b1000, 1'b0, 1'b1);
`else
    step(); expect_state("cu1", 4'b0101, 1'b0, 1'b0);
    step(); expect_state("cu2", 4'b0101, 1'b0, 1'b0);
    step(); expect_state("cu3", 4'b0101, 1'b0, 1'b0);
`endif

    // en=0 freezes the counter
    en = 1'b0; step();
`ifdef JK_COUNT_MODE_EN
    expect_state("cnt_en0", 4'b1000, 1'b0, 1'b0);
`else
    expect_state("cnt_en0", 4'b0101, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_jk_reg_bank

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised bank of WIDTH JK flip-flops sharing one clock, with per-bit J/K inputs, parallel load, clock enable and an optional synchronous up/down counter mode built from the same JK cells. It is the multi-bit, multi-mode successor to the single-bit JK flip-flop in the sequential library. It serves as a general state/flag register or small counter in the sequential examples.

## Interface
- WIDTH, 8, number of JK bits (≥1)
- RST_VAL, 0, WIDTH-bit value loaded into q on reset
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- en  input  1  clock enable for JK and count operation
- load  input  1  synchronous parallel load
- d  input  WIDTH  parallel load data
- mode  input  2  00 JK, 01 count up, 10 count down, 11 hold
- j  input  WIDTH  per-bit J
- k  input  WIDTH  per-bit K
- q  output  WIDTH  register state
- tc  output  1  registered terminal-count pulse
- chg  output  1  registered flag: q changed on the last edge

## Operation
- Reset (rst=0): q=RST_VAL, tc=0, chg=0 immediately, independent of clk.
- Each rising edge with rst=1 is evaluated in this priority order:
  - load=1: q←d, regardless of en and mode; tc←0.
  - en=0: q holds; tc←0.
  - mode 00: per bit, JK=00 holds, 01 clears, 10 sets, 11 toggles.
  - mode 01: q←q+1 mod 2^WIDTH. Each bit's J=K=AND of all lower bits; bit 0 always toggles.
  - mode 10: q←q−1 mod 2^WIDTH. Each bit's J=K=AND of all inverted lower bits.
  - mode 11: q holds.
- tc←1 only on an edge where the count wraps: up from all-ones to 0, or down from 0 to all-ones. Otherwise tc←0, including in JK mode.
- chg←1 if the new q differs from the old q, else 0. Load of an equal value gives chg=0.
- j/k are ignored outside mode 00, and also when load=1 or en=0.

## Timing
- Latency is 1 cycle: inputs sampled on edge N are visible on q, tc and chg after edge N.
- tc and chg are single-cycle pulses aligned with the new q value.
- Reset assertion is asynchronous. Deassertion is sampled normally; the first edge with rst=1 operates from RST_VAL.
- Reset asserted mid-count aborts the count. After release, counting resumes from RST_VAL.
- Mode may change on any edge with no dead cycle. The new mode applies at that edge.
- There are no combinational paths from inputs to outputs.

## Configuration
- JK_COUNT_MODE_EN defined: modes 01/10 and the tc output behave as described above.
- JK_COUNT_MODE_EN undefined: the counter chain is compiled out, and modes 01 and 10 act as 11 (hold).
  - tc is tied to 0.
  - The port list is unchanged.

## Structure
- Package jk_pkg holds:
  - typedef jk_mode_t with values JK_MODE_JK=2'b00, JK_MODE_UP=2'b01, JK_MODE_DN=2'b10, JK_MODE_HOLD=2'b11
  - the constant JK_PKG_MAX_WIDTH=64
- Sub-module jk_cell: one-bit JK flip-flop with asynchronous active-low reset, reset value, load, load data and enable. The top level generates WIDTH instances of it.
- The top level holds the per-bit J/K select muxes, the carry/borrow AND chains, and the tc/chg registers.

## Test plan
All scenarios use WIDTH=4, RST_VAL=4'b0000 and JK_COUNT_MODE_EN defined unless stated otherwise.
- Async reset: drive rst=0 between clock edges while q=4'b1011 → q=0000, tc=0 and chg=0 before the next edge.
- JK mode, q=0000:
  - j=1010, k=0000 → q=1010, chg=1.
  - j=0000, k=0010 → q=1000.
  - j=k=1111 → q=0111.
  - j=k=0000 → q=0111, chg=0.
- Load priority: en=0, load=1, d=1001, mode=00, j=k=1111 → q=1001. Then load=0, en=0 → q holds 1001, chg=0.
- Count up: load 1110, then mode=01, en=1 → q=1111 (tc=0), 0000 (tc=1), 0001 (tc=0).
- Count down: load 0001, mode=10 → q=0000 (tc=0), 1111 (tc=1), 1110 (tc=0). Pulse rst=0 mid-run → q=0000; after release, the next edge gives q=1111, tc=1.
- Macro undefined: load 0101, mode=01, en=1 for 3 edges → q stays 0101, tc=0 throughout.
